// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI round-robin bus arbiter.
package pci_arb_pkg;

    localparam int N_REQ_DEF       = 5;
    localparam int GNT_TIMEOUT_DEF = 16;
    // Grant timer width; covers any GNT_TIMEOUT up to 255.
    localparam int TMR_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Round-robin priority picker: first requester at or after ptr, wrapping modulo N_REQ.
module pci_rr_pick
    import pci_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = ptr_width(N_REQ)
)(
    input  logic [N_REQ-1:0] i_req_n,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_winner,
    output logic             o_found
);

    localparam int            SW  = PTR_W + 1;
    localparam logic [SW-1:0] W_N = SW'(N_REQ);

    logic [SW-1:0]    w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        // Scan from the farthest slot back toward ptr so the nearest request wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= W_N) begin
                w_sum = w_sum - W_N;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!i_req_n[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/pci_rr_arbiter.sv
// PCI central bus arbiter: round-robin grants, hidden arbitration, grant timeout.
module pci_rr_arbiter
    import pci_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             FRAME,
    input  logic             IRDY,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [2:0]       OWNER,
    output logic             OWNER_VALID
);

    localparam int               PTR_W    = ptr_width(N_REQ);
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(N_REQ - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(GNT_TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ALL_HI   = '1;

    arb_state_e       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [PTR_W-1:0] r_owner, w_owner_nxt;
    logic             r_owner_vld, w_owner_vld_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [PTR_W-1:0] r_pg, w_pg_nxt;
    logic             r_pg_vld, w_pg_vld_nxt;

    logic [PTR_W-1:0] w_win;
    logic             w_found;
    logic             w_bus_idle;
    logic [N_REQ-1:0] w_gnt_win;
    logic [PTR_W-1:0] w_ptr_inc;

    pci_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req_n  (REQ),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_found  (w_found)
    );

    assign w_bus_idle = FRAME & IRDY;
    assign w_gnt_win  = ALL_HI ^ (N_REQ'(1) << w_win);
    assign w_ptr_inc  = (r_owner == LAST) ? '0 : r_owner + PTR_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_owner_nxt     = r_owner;
        w_owner_vld_nxt = r_owner_vld;
        w_ptr_nxt       = r_ptr;
        w_timer_nxt     = '0;
        w_pg_nxt        = r_pg;
        w_pg_vld_nxt    = r_pg_vld;

        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt       = ALL_HI;
                w_owner_vld_nxt = 1'b0;
                w_pg_vld_nxt    = 1'b0;
                if (w_bus_idle && w_found) begin
                    w_gnt_nxt       = w_gnt_win;
                    w_owner_nxt     = w_win;
                    w_owner_vld_nxt = 1'b1;
                    w_state_nxt     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                // FRAME wins over both a request release and a timeout in the same cycle.
                if (!FRAME) begin
                    w_state_nxt  = ST_BUSY;
                    w_gnt_nxt    = ALL_HI;
                    w_ptr_nxt    = w_ptr_inc;
                    w_pg_vld_nxt = 1'b0;
                end else if (REQ[r_owner]) begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = ALL_HI;
                    w_owner_vld_nxt = 1'b0;
                end else if (r_timer == TMO_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = ALL_HI;
                    w_owner_vld_nxt = 1'b0;
                    w_ptr_nxt       = w_ptr_inc;
                end
            end

            ST_BUSY: begin
                if (w_bus_idle) begin
                    w_pg_vld_nxt = 1'b0;
                    if (r_pg_vld && !REQ[r_pg]) begin
                        w_state_nxt = ST_GRANT;
                        w_owner_nxt = r_pg;
                    end else begin
                        w_state_nxt     = ST_IDLE;
                        w_gnt_nxt       = ALL_HI;
                        w_owner_vld_nxt = 1'b0;
                    end
                end else if (r_pg_vld) begin
                    // Pre-grantee withdrew: park GNT high for a cycle, then re-arbitrate.
                    if (REQ[r_pg]) begin
                        w_gnt_nxt    = ALL_HI;
                        w_pg_vld_nxt = 1'b0;
                    end
                end else if (w_found) begin
                    w_gnt_nxt    = w_gnt_win;
                    w_pg_nxt     = w_win;
                    w_pg_vld_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_gnt_nxt       = ALL_HI;
                w_owner_vld_nxt = 1'b0;
                w_pg_vld_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= ALL_HI;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            r_ptr       <= '0;
            r_timer     <= '0;
            r_pg        <= '0;
            r_pg_vld    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_owner     <= w_owner_nxt;
            r_owner_vld <= w_owner_vld_nxt;
            r_ptr       <= w_ptr_nxt;
            r_timer     <= w_timer_nxt;
            r_pg        <= w_pg_nxt;
            r_pg_vld    <= w_pg_vld_nxt;
        end
    end

    assign GNT         = r_gnt;
    assign OWNER       = 3'(r_owner);
    assign OWNER_VALID = r_owner_vld;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: directed bus scenarios plus random traffic against a rule-level model.
module tb_pci_rr_arbiter;

    localparam int         N    = 5;
    localparam int         TO   = 16;
    localparam logic [4:0] ONES = 5'b11111;

    logic       clk = 1'b0;
    logic       rst;
    logic       FRAME;
    logic       IRDY;
    logic [4:0] REQ;
    logic [4:0] GNT;
    logic [2:0] OWNER;
    logic       OWNER_VALID;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 granted-awaiting-FRAME, 2 bus busy.
    int   m_phase, m_ptr, m_cnt, m_gnt, m_owner;
    bit   m_ovld;
    logic [4:0] prev_gnt;

    pci_rr_arbiter #(.N_REQ(N), .GNT_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .FRAME       (FRAME),
        .IRDY        (IRDY),
        .REQ         (REQ),
        .GNT         (GNT),
        .OWNER       (OWNER),
        .OWNER_VALID (OWNER_VALID)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [4:0] r, input int p);
        int a;
        for (int k = 0; k < N; k++) begin
            a = (p + k) % N;
            if (!r[3'(a)]) return a;
        end
        return -1;
    endfunction

    function automatic int low_index(input logic [4:0] g);
        for (int k = 0; k < N; k++) begin
            if (!g[3'(k)]) return k;
        end
        return -1;
    endfunction

    function automatic logic [4:0] exp_gnt();
        logic [4:0] one;
        one = 5'b00001;
        return (m_gnt < 0) ? ONES : ~(one << m_gnt);
    endfunction

    task automatic model_edge();
        int w;
        bit idle;
        idle = FRAME && IRDY;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_cnt = 0; m_gnt = -1; m_owner = 0; m_ovld = 0;
            return;
        end
        w = pick(REQ, m_ptr);
        case (m_phase)
            0: begin
                m_gnt = -1; m_ovld = 0;
                if (idle && w >= 0) begin
                    m_gnt = w; m_owner = w; m_ovld = 1; m_cnt = 0; m_phase = 1;
                end
            end
            1: begin
                m_cnt++;
                if (!FRAME) begin
                    m_phase = 2; m_gnt = -1; m_ptr = (m_owner + 1) % N;
                end else if (REQ[3'(m_owner)]) begin
                    m_phase = 0; m_gnt = -1; m_ovld = 0;
                end else if (m_cnt >= TO) begin
                    m_phase = 0; m_gnt = -1; m_ovld = 0; m_ptr = (m_owner + 1) % N;
                end
            end
            default: begin
                if (idle) begin
                    if (m_gnt >= 0 && !REQ[3'(m_gnt)]) begin
                        m_phase = 1; m_owner = m_gnt; m_cnt = 0;
                    end else begin
                        m_phase = 0; m_gnt = -1; m_ovld = 0;
                    end
                end else if (m_gnt >= 0) begin
                    if (REQ[3'(m_gnt)]) m_gnt = -1;
                end else if (w >= 0) begin
                    m_gnt = w;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("gnt_model", 32'(GNT), 32'(exp_gnt()));
        chk("owner_valid_model", 32'(OWNER_VALID), 32'(m_ovld));
        if (m_ovld) chk("owner_model", 32'(OWNER), 32'(m_owner));
        chk("gnt_onehot", 32'($countones(~GNT) <= 1), 32'd1);
        if (prev_gnt != ONES && GNT != ONES) chk("gnt_no_direct_switch", 32'(GNT), 32'(prev_gnt));
        prev_gnt = GNT;
    endtask

    task automatic drive(input logic f, input logic i, input logic [4:0] r);
        FRAME = f;
        IRDY  = i;
        REQ   = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, ONES);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int ag;
        int fpct;
        int ipct;

        rst = 1'b1;
        drive(1'b1, 1'b1, ONES);
        prev_gnt = ONES;
        m_phase = 0; m_ptr = 0; m_cnt = 0; m_gnt = -1; m_owner = 0; m_ovld = 0;

        // Reset state and quiet bus
        step();
        step();
        chk("rst_gnt", 32'(GNT), 32'(ONES));
        chk("rst_owner", 32'(OWNER), 32'd0);
        chk("rst_owner_valid", 32'(OWNER_VALID), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("quiet_gnt", 32'(GNT), 32'(ONES));
            chk("quiet_owner_valid", 32'(OWNER_VALID), 32'd0);
        end

        // Single agent 4 transaction, pointer wraps to 0
        drive(1'b1, 1'b1, 5'b01111);
        step();
        chk("a4_gnt", 32'(GNT), 32'(5'b01111));
        chk("a4_owner", 32'(OWNER), 32'd4);
        step();
        chk("a4_gnt_hold", 32'(GNT), 32'(5'b01111));
        drive(1'b0, 1'b0, ONES);
        step();
        chk("a4_frame_gnt_off", 32'(GNT), 32'(ONES));
        chk("a4_busy_owner", 32'(OWNER), 32'd4);
        drive(1'b1, 1'b0, ONES);
        step();
        drive(1'b1, 1'b1, ONES);
        step();
        chk("a4_idle_owner_valid", 32'(OWNER_VALID), 32'd0);
        drive(1'b1, 1'b1, 5'b01110);
        step();
        chk("a4_ptr_wrapped", 32'(GNT), 32'(5'b11110));

        // Agents 3 and 4 alternate with hidden arbitration
        do_reset();
        drive(1'b1, 1'b1, 5'b00111);
        for (int t = 0; t < 4; t++) begin
            cnt = 0;
            step();
            while (GNT == ONES && cnt < 20) begin
                step();
                cnt++;
            end
            chk("alt_wait_bound", 32'(cnt < 20), 32'd1);
            ag = low_index(GNT);
            chk("alt_order", 32'(ag), (t % 2 == 0) ? 32'd3 : 32'd4);
            drive(1'b0, 1'b0, 5'b00111);
            step();
            chk("alt_frame_gnt_off", 32'(GNT), 32'(ONES));
            step();
            drive(1'b1, 1'b0, 5'b00111);
            step();
            drive(1'b1, 1'b1, 5'b00111);
        end

        // Grant timeout for agent 3, then agent 4
        do_reset();
        drive(1'b1, 1'b1, 5'b00111);
        step();
        cnt = 0;
        while (GNT == 5'b10111 && cnt < 40) begin
            cnt++;
            step();
        end
        chk("tmo_hold_cycles", 32'(cnt), 32'd16);
        chk("tmo_gap", 32'(GNT), 32'(ONES));
        step();
        chk("tmo_next_a4", 32'(GNT), 32'(5'b01111));

        // Pre-grant of agent 3 during agent 4 transaction
        do_reset();
        drive(1'b1, 1'b1, 5'b01111);
        step();
        chk("pg_a4_gnt", 32'(GNT), 32'(5'b01111));
        drive(1'b0, 1'b0, 5'b10111);
        step();
        chk("pg_busy_gap", 32'(GNT), 32'(ONES));
        step();
        chk("pg_a3_gnt", 32'(GNT), 32'(5'b10111));
        chk("pg_owner_bus", 32'(OWNER), 32'd4);
        drive(1'b1, 1'b0, 5'b10111);
        step();
        chk("pg_hold", 32'(GNT), 32'(5'b10111));
        drive(1'b1, 1'b1, 5'b10111);
        step();
        chk("pg_grant_owner", 32'(OWNER), 32'd3);
        drive(1'b0, 1'b0, ONES);
        step();
        chk("pg_a3_busy_gnt", 32'(GNT), 32'(ONES));
        chk("pg_a3_busy_owner", 32'(OWNER), 32'd3);
        drive(1'b1, 1'b1, ONES);
        step();

        // Reset mid-transaction: no grant until idle bus sampled
        do_reset();
        drive(1'b1, 1'b1, 5'b01111);
        step();
        chk("mr_gnt", 32'(GNT), 32'(5'b01111));
        drive(1'b0, 1'b0, 5'b01111);
        rst = 1'b1;
        step();
        chk("mr_gnt_cleared", 32'(GNT), 32'(ONES));
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mr_no_grant_busy", 32'(GNT), 32'(ONES));
        end
        drive(1'b1, 1'b0, 5'b01111);
        step();
        chk("mr_no_grant_irdy", 32'(GNT), 32'(ONES));
        drive(1'b1, 1'b1, 5'b01111);
        step();
        chk("mr_grant_after_idle", 32'(GNT), 32'(5'b01111));

        // Random traffic against the model
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 3))
                0:       fpct = 0;
                1:       fpct = 10;
                2:       fpct = 30;
                default: fpct = 60;
            endcase
            ipct = $urandom_range(0, 50);
            for (int c = 0; c < 50; c++) begin
                if ($urandom_range(0, 9) == 0) REQ = 5'($urandom_range(0, 31));
                FRAME = ($urandom_range(0, 99) < fpct) ? 1'b0 : 1'b1;
                IRDY  = ($urandom_range(0, 99) < ipct) ? 1'b0 : 1'b1;
                rst   = ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0;
                step();
            end
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pci_rr_arbiter.md
PCI_RR_ARBITER -- requirements
Module: pci_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 5, number of requesters (max 8).
REQ-002 Parameter GNT_TIMEOUT, default 16, cycles a grantee may hold GNT without asserting FRAME.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 FRAME  input  1  PCI FRAME#, active-low, pulled up.
REQ-006 IRDY  input  1  PCI IRDY#, active-low, pulled up.
REQ-007 REQ  input  N_REQ  per-agent request, active-low; bit i = agent i.
REQ-008 GNT  output  N_REQ  per-agent grant, active-low, at most one bit low.
REQ-009 OWNER  output  3  index of agent whose GNT is low, or of current bus owner.
REQ-010 OWNER_VALID  output  1  high when OWNER is meaningful.

Function
REQ-011 Bus idle SHALL be FRAME==1 && IRDY==1, sampled at the rising edge.
REQ-012 FSM SHALL have states IDLE, GRANT, BUSY; every output is registered.
REQ-013 Winner SHALL be the lowest index >= ptr with REQ low, wrapping modulo N_REQ; ptr is a log2(N_REQ)-bit register.
REQ-014 IDLE: if bus idle and any REQ low -> GNT[winner] low next edge, timer=0, state GRANT; else all GNT high.
REQ-015 GRANT: FRAME sampled low -> BUSY, ptr <= (owner+1) mod N_REQ, GNT all high next edge.
REQ-016 GRANT: grantee REQ sampled high before FRAME -> GNT all high, ptr unchanged, state IDLE.
REQ-017 GRANT: timer reaching GNT_TIMEOUT without FRAME -> GNT all high, ptr <= (owner+1) mod N_REQ, state IDLE.
REQ-018 FRAME low in the same cycle as timeout or REQ release SHALL take precedence (-> BUSY).
REQ-019 BUSY (hidden arbitration): GNT all high for at least one cycle after FRAME is seen; then if any REQ low, GNT[winner] low while bus stays busy; OWNER tracks the bus owner until idle.
REQ-020 BUSY: bus idle sampled -> GRANT with the pre-granted agent (timer=0) if one exists, else IDLE.
REQ-021 Between any two different low GNT bits there SHALL be at least one cycle with all GNT high.
REQ-022 A pre-granted agent dropping REQ during BUSY SHALL lose GNT next edge, with re-arbitration one cycle later.

Reset
REQ-023 rst high at a clock edge SHALL force state IDLE, GNT all ones, ptr=0, timer=0, OWNER=0, OWNER_VALID=0.
REQ-024 Reset mid-transaction SHALL NOT issue any grant until bus idle is sampled (covered by REQ-014).

Structure
REQ-025 Package pci_arb_pkg SHALL hold the state enum, N_REQ default, and timer width constant.
REQ-026 Sub-module pci_rr_pick (combinational: REQ, ptr -> winner index, found) SHALL be the only priority logic.

Verification
REQ-027 Reset, REQ=5'b11111, bus idle -> GNT=5'b11111, OWNER_VALID=0 for 10 cycles.
REQ-028 REQ[4] low at cycle 2, FRAME low 2 cycles after GNT[4] low -> GNT=5'b01111 then 5'b11111 on FRAME; ptr=0.
REQ-029 REQ[4] and REQ[3] held low, each master runs a 3-cycle transaction -> grants alternate 3,4,3,4 with >=1 all-high GNT cycle between.
REQ-030 REQ[3] low, no FRAME -> GNT[3] low exactly 16 cycles, then all high; REQ[4] low at the same time -> GNT[4] next.
REQ-031 During an agent-4 transaction REQ[3] low -> GNT[3] low while FRAME low; GRANT entered on bus idle; agent 3 FRAME in cycle 1 -> BUSY.
REQ-032 rst pulsed while FRAME low and GNT[4] low -> GNT all high next edge; no grant until FRAME and IRDY high.
